// File: rtl/im_arbiter_if.sv
// ---------------------------------------------------------------------------
// im_arbiter_if
// Bundles the fetch-side and memory-side signals of the instruction memory
// arbiter so that one port connects the arbiter to its environment.
//
// Signals (direction as seen by the arbiter, modport "master"):
//   arb_en          in   global arbitration enable
//   core_req        in   per-core fetch request, held until granted
//   core_addr       in   packed per-core fetch addresses (core i at i*ADDR_W)
//   core_flush      in   per-core kill of request and of pending response
//   core_gnt        out  one-hot combinational grant
//   core_rsp_valid  out  one-hot response strobe, one cycle after grant
//   core_instr      out  broadcast instruction word (equals mem_instr)
//   mem_addr        out  registered instruction memory address
//   mem_rd_en       out  registered instruction memory read enable
//   mem_instr       in   instruction memory read data (changes on negedge)
//
// The "slave" modport is the mirror view used by the cores and the memory.
// ---------------------------------------------------------------------------
interface im_arbiter_if #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 16,
    parameter int INSTR_W   = 48
);
    logic                        arb_en;
    logic [NUM_CORES-1:0]        core_req;
    logic [NUM_CORES*ADDR_W-1:0] core_addr;
    logic [NUM_CORES-1:0]        core_flush;
    logic [NUM_CORES-1:0]        core_gnt;
    logic [NUM_CORES-1:0]        core_rsp_valid;
    logic [INSTR_W-1:0]          core_instr;
    logic [ADDR_W-1:0]           mem_addr;
    logic                        mem_rd_en;
    logic [INSTR_W-1:0]          mem_instr;

    modport master (
        input  arb_en,
        input  core_req,
        input  core_addr,
        input  core_flush,
        input  mem_instr,
        output core_gnt,
        output core_rsp_valid,
        output core_instr,
        output mem_addr,
        output mem_rd_en
    );

    modport slave (
        output arb_en,
        output core_req,
        output core_addr,
        output core_flush,
        output mem_instr,
        input  core_gnt,
        input  core_rsp_valid,
        input  core_instr,
        input  mem_addr,
        input  mem_rd_en
    );
endinterface

// File: rtl/im_arbiter.sv
// ---------------------------------------------------------------------------
// im_arbiter
// Round-robin arbiter sharing a single-ported, negedge-read instruction
// memory among NUM_CORES fetch units. At most one request is granted per
// cycle; the grant is combinational, the memory address/read enable are
// registered at the following posedge, and the returned word is routed to
// the owning core during that next cycle.
//
// Ports:
//   clk   system clock, all state updates on posedge
//   rst   asynchronous, active-high reset
//   bus   im_arbiter_if.master (core request/grant/response + memory side)
//
// Parameters:
//   NUM_CORES  number of requesting cores (2..8)
//   ADDR_W     instruction address width
//   INSTR_W    instruction word width
// ---------------------------------------------------------------------------
module im_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 16,
    parameter int INSTR_W   = 48
) (
    input  logic          clk,
    input  logic          rst,
    im_arbiter_if.master  bus
);

    localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_CORES - 1);

    logic [PTR_W-1:0]     ptr_q;
    logic [PTR_W-1:0]     ptr_d;
    logic [NUM_CORES-1:0] owner_q;
    logic [ADDR_W-1:0]    mem_addr_q;
    logic                 mem_rd_en_q;

    logic [NUM_CORES-1:0] elig;
    logic [NUM_CORES-1:0] gnt;
    logic [PTR_W-1:0]     win_idx;
    logic                 win_found;
    logic [ADDR_W-1:0]    win_addr;
    int                   cand_idx;

    // A flushed core is masked out of arbitration in the same cycle. Nothing
    // is granted while reset is held so no core believes it was accepted.
    always_comb begin
        elig = '0;
        if (bus.arb_en && !rst) begin
            elig = bus.core_req & ~bus.core_flush;
        end
    end

    // Search starts at ptr and wraps modulo NUM_CORES; the first eligible
    // core found wins. NUM_CORES need not be a power of two, hence the
    // explicit wrap instead of relying on pointer overflow.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_idx  = 0;
        for (int off = 0; off < NUM_CORES; off++) begin
            cand_idx = int'(ptr_q) + off;
            if (cand_idx >= NUM_CORES) begin
                cand_idx = cand_idx - NUM_CORES;
            end
            if (!win_found && elig[PTR_W'(cand_idx)]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(cand_idx);
            end
        end
    end

    // One-hot grant and the winner's address slice (AND-OR mux).
    always_comb begin
        gnt      = '0;
        win_addr = '0;
        if (win_found) begin
            gnt[win_idx] = 1'b1;
        end
        for (int i = 0; i < NUM_CORES; i++) begin
            if (gnt[i]) begin
                win_addr = bus.core_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Pointer moves to the core just after the winner so the winner gets
    // lowest priority next time.
    always_comb begin
        ptr_d = ptr_q;
        if (win_found) begin
            ptr_d = (win_idx == LAST_IDX) ? '0 : win_idx + PTR_W'(1);
        end
    end

    // mem_addr and ptr hold when idle; read enable and ownership clear so a
    // stale owner never sees a second response strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr_q  <= '0;
            mem_rd_en_q <= 1'b0;
            owner_q     <= '0;
            ptr_q       <= '0;
        end else if (win_found) begin
            mem_addr_q  <= win_addr;
            mem_rd_en_q <= 1'b1;
            owner_q     <= gnt;
            ptr_q       <= ptr_d;
        end else begin
            mem_rd_en_q <= 1'b0;
            owner_q     <= '0;
        end
    end

    // A flush arriving in the response cycle suppresses only the strobe; the
    // memory read has already been issued and is simply ignored.
    assign bus.core_gnt       = gnt;
    assign bus.core_rsp_valid = owner_q & ~bus.core_flush;
    assign bus.core_instr     = bus.mem_instr;
    assign bus.mem_addr       = mem_addr_q;
    assign bus.mem_rd_en      = mem_rd_en_q;

endmodule

// File: tb/tb_im_arbiter.sv
// ---------------------------------------------------------------------------
// tb_im_arbiter
// Directed scoreboard bench for im_arbiter (4 cores). Each stimulus step
// drives one cycle of requests and checks the hand-computed grant; granted
// fetches push the expected (owner, instruction) pair into a queue which a
// monitor pops whenever the arbiter strobes a response. A small negedge
// instruction memory model supplies mem_instr.
// ---------------------------------------------------------------------------
module tb_im_arbiter;

    localparam int NC = 4;
    localparam int AW = 16;
    localparam int IW = 48;

    logic clk;
    logic rst;

    int checks;
    int errors;
    int rsp_count [NC];

    logic [NC+IW-1:0] exp_q [$];
    logic [NC-1:0]    prev_gnt;
    logic [AW-1:0]    prev_addr;

    im_arbiter_if #(.NUM_CORES(NC), .ADDR_W(AW), .INSTR_W(IW)) bus ();

    im_arbiter #(.NUM_CORES(NC), .ADDR_W(AW), .INSTR_W(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [IW-1:0] instr_word(input logic [AW-1:0] a);
        return {a, ~a, a ^ 16'h5A3C};
    endfunction

    function automatic logic [AW-1:0] addr_of(input logic [NC-1:0] g);
        logic [AW-1:0] r;
        r = '0;
        for (int i = 0; i < NC; i++) begin
            if (g[i]) r = bus.core_addr[i*AW +: AW];
        end
        return r;
    endfunction

    // Negedge-read instruction memory.
    initial bus.mem_instr = '0;
    always @(negedge clk) begin
        if (bus.mem_rd_en) bus.mem_instr <= instr_word(bus.mem_addr);
    end

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus: drive just after posedge, then check the
    // combinational grant plus what the previous grant should have produced.
    task automatic applyStimulus(input logic [NC-1:0] req, input logic [NC-1:0] flush,
                                 input logic en, input logic [NC-1:0] exp_gnt,
                                 input bit push_rsp);
        @(posedge clk);
        #1;
        bus.core_req   = req;
        bus.core_flush = flush;
        bus.arb_en     = en;
        #1;
        checkOutput("core_gnt", 64'(bus.core_gnt), 64'(exp_gnt));
        checkOutput("mem_rd_en", 64'(bus.mem_rd_en), 64'(|prev_gnt));
        if (|prev_gnt) checkOutput("mem_addr", 64'(bus.mem_addr), 64'(prev_addr));
        checkOutput("core_rsp_valid", 64'(bus.core_rsp_valid), 64'(prev_gnt & ~flush));
        prev_gnt  = exp_gnt;
        prev_addr = addr_of(exp_gnt);
        if (push_rsp && (|exp_gnt)) exp_q.push_back({exp_gnt, instr_word(addr_of(exp_gnt))});
    endtask

    // Response monitor: samples after the memory's negedge update.
    initial begin
        logic [NC+IW-1:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (|bus.core_rsp_valid) begin
                for (int i = 0; i < NC; i++) begin
                    if (bus.core_rsp_valid[i]) rsp_count[i]++;
                end
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_rsp", 64'(bus.core_rsp_valid), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("rsp_owner", 64'(bus.core_rsp_valid), 64'(e[NC+IW-1:IW]));
                    checkOutput("rsp_instr", 64'(bus.core_instr), 64'(e[IW-1:0]));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks    = 0;
        errors    = 0;
        prev_gnt  = '0;
        prev_addr = '0;
        for (int i = 0; i < NC; i++) rsp_count[i] = 0;
        rst            = 1'b1;
        bus.arb_en     = 1'b1;
        bus.core_req   = 4'b1111;
        bus.core_flush = 4'b0000;
        bus.core_addr  = {16'h3FFC, 16'h0010, 16'h2004, 16'h1000};

        // Reset with all cores requesting: nothing granted or issued.
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_gnt", 64'(bus.core_gnt), 64'(0));
        checkOutput("rst_rd_en", 64'(bus.mem_rd_en), 64'(0));
        checkOutput("rst_rsp", 64'(bus.core_rsp_valid), 64'(0));
        checkOutput("rst_mem_addr", 64'(bus.mem_addr), 64'(0));
        bus.core_req = 4'b0000;
        rst = 1'b0;

        // Fairness: all requesting, grants rotate starting at core 0.
        applyStimulus(4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b1);
        applyStimulus(4'b1111, 4'b0000, 1'b1, 4'b0010, 1'b1);
        applyStimulus(4'b1111, 4'b0000, 1'b1, 4'b0100, 1'b1);
        applyStimulus(4'b1111, 4'b0000, 1'b1, 4'b1000, 1'b1);
        applyStimulus(4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b1);
        applyStimulus(4'b1111, 4'b0000, 1'b1, 4'b0010, 1'b1);
        applyStimulus(4'b1111, 4'b0000, 1'b1, 4'b0100, 1'b1);
        applyStimulus(4'b1111, 4'b0000, 1'b1, 4'b1000, 1'b1);

        // Single core 2 at address 0x0010 (ptr back at 0 -> 3 afterwards).
        applyStimulus(4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b1);
        @(negedge clk);
        #2;
        for (int i = 0; i < NC; i++) checkOutput($sformatf("rsp_count%0d", i), 64'(rsp_count[i]), 64'(2));

        // Wrap/skip: ptr=3, only core 1 -> 1, ptr=2; then {1,0} -> 0.
        applyStimulus(4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b1);
        applyStimulus(4'b0011, 4'b0000, 1'b1, 4'b0001, 1'b1);

        // Flush: grant core 2, then flush it in the response cycle while it
        // still requests; then masked core 2 lets core 0 win.
        applyStimulus(4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b0);
        applyStimulus(4'b0100, 4'b0100, 1'b1, 4'b0000, 1'b0);
        applyStimulus(4'b0101, 4'b0100, 1'b1, 4'b0001, 1'b1);

        // arb_en: ptr=1 grants core 1, then disabled for two cycles (owed
        // response still arrives), then resumes at core 2.
        applyStimulus(4'b1111, 4'b0000, 1'b1, 4'b0010, 1'b1);
        applyStimulus(4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b0);
        applyStimulus(4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b0);
        applyStimulus(4'b1111, 4'b0000, 1'b1, 4'b0100, 1'b1);

        // Mid-operation reset kills the in-flight response for core 1.
        applyStimulus(4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("midrst_rsp", 64'(bus.core_rsp_valid), 64'(0));
        checkOutput("midrst_rd_en", 64'(bus.mem_rd_en), 64'(0));
        checkOutput("midrst_mem_addr", 64'(bus.mem_addr), 64'(0));
        checkOutput("midrst_gnt", 64'(bus.core_gnt), 64'(0));
        @(negedge clk);
        #1;
        bus.core_req = 4'b0000;
        rst = 1'b0;
        prev_gnt = '0;

        // ptr restarted at 0: core 2 alone wins; then drain.
        applyStimulus(4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b1);
        applyStimulus(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0);
        @(negedge clk);
        #2;
        checkOutput("queue_empty", 64'(exp_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
